acc_cpu_param: RTL and testbench

- Parametrised multicycle accumulator processor; next generation of the lab top-level CPU (input port A, Output register, Halt_out).
- Adds generic data width and memory depths, a runtime-loadable program memory, data RAM, carry flag, conditional branches, output strobe, and start/auto-run control.
- Sits as the top compute block; the bench drives A, loads the program, and observes Output/Halt_out.

---
 rtl/acc_cpu_param.sv | 151 +++++++++++++++
 tb/tb_acc_cpu_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_param.sv
// acc_cpu_param: parametrised two-cycle-per-instruction accumulator CPU.
//
// Each instruction is fetched from a runtime-loadable program memory in one
// cycle and executed in the next. The instruction word is
// {opcode[3:0], operand[DATA_W-1:0]}. The datapath is an accumulator, a
// carry flag and a small data RAM addressed by the low operand bits.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        synchronous active-low reset
//   A          external operand, loaded by LDA
//   start      run from PC=0 when IDLE or HALT
//   prog_we    program-memory write strobe (accepted only in IDLE/HALT)
//   prog_addr  program write address
//   prog_data  program write word {opcode, operand}
//   Output     output register, written by OUT
//   out_valid  one-cycle pulse in the cycle Output shows a new value
//   Halt_out   high while halted
//   busy       high while fetching or executing
module acc_cpu_param #(
    parameter int DATA_W    = 8,
    parameter int PC_W      = 5,
    parameter int DM_AW     = 4,
    parameter bit AUTOSTART = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] A,
    input  logic              start,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [DATA_W+3:0] prog_data,
    output logic [DATA_W-1:0] Output,
    output logic              out_valid,
    output logic              Halt_out,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR,  OP_ST,
        OP_LD,  OP_JMP, OP_JZ,  OP_JC,  OP_OUT, OP_ADDI, OP_SHL, OP_HLT
    } opcode_t;

    state_t state, state_nx;

    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] acc;
    logic              c;
    logic [DATA_W+3:0] ir;

    logic [DATA_W+3:0] pmem [2**PC_W];
    logic [DATA_W-1:0] dram [2**DM_AW];

    opcode_t           op;
    logic [DATA_W-1:0] opr;
    logic [DM_AW-1:0]  daddr;
    logic [PC_W-1:0]   target;
    logic [DATA_W-1:0] mval;
    logic [DATA_W:0]   sum_m;
    logic [DATA_W:0]   sum_i;
    logic              idle_like;

    assign op     = opcode_t'(ir[DATA_W+3:DATA_W]);
    assign opr    = ir[DATA_W-1:0];
    assign daddr  = opr[DM_AW-1:0];
    assign target = opr[PC_W-1:0];
    assign mval   = dram[daddr];
    // One extra bit on each sum captures the carry out.
    assign sum_m  = {1'b0, acc} + {1'b0, mval};
    assign sum_i  = {1'b0, acc} + {1'b0, opr};

    assign idle_like = (state == S_IDLE) || (state == S_HALT);
    assign Halt_out  = (state == S_HALT);
    assign busy      = (state == S_FETCH) || (state == S_EXEC);

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // IDLE is only entered through reset, so AUTOSTART alone is enough to
    // leave it on the first cycle after reset; HALT always waits for start.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start || AUTOSTART) state_nx = S_FETCH;
            S_FETCH: state_nx = S_EXEC;
            S_EXEC:  state_nx = (op == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:  if (start) state_nx = S_FETCH;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= '0;
            acc       <= '0;
            c         <= 1'b0;
            ir        <= '0;
            Output    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (state_nx == S_FETCH) begin
                        pc  <= '0;
                        acc <= '0;
                        c   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir <= pmem[pc];
                    pc <= pc + 1'b1;
                end
                S_EXEC: begin
                    case (op)
                        OP_LDI:  acc <= opr;
                        OP_LDA:  acc <= A;
                        OP_ADD:  {c, acc} <= sum_m;
                        OP_SUB:  begin acc <= acc - mval; c <= (acc < mval); end
                        OP_AND:  acc <= acc & mval;
                        OP_OR:   acc <= acc | mval;
                        OP_LD:   acc <= mval;
                        OP_JMP:  pc <= target;
                        OP_JZ:   if (acc == '0) pc <= target;
                        OP_JC:   if (c) pc <= target;
                        OP_OUT:  begin Output <= acc; out_valid <= 1'b1; end
                        OP_ADDI: {c, acc} <= sum_i;
                        OP_SHL:  begin c <= acc[DATA_W-1]; acc <= {acc[DATA_W-2:0], 1'b0}; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Memories are never cleared. Gating on rst means a reset landing on an
    // EXEC of ST aborts the store, and a fetch issued right after a write
    // in the start cycle sees the new word through the combinational read.
    always_ff @(posedge clk) begin
        if (rst && prog_we && idle_like)
            pmem[prog_addr] <= prog_data;
        if (rst && state == S_EXEC && op == OP_ST)
            dram[daddr] <= acc;
    end

endmodule

// File: tb/tb_acc_cpu_param.sv
module tb_acc_cpu_param;
    localparam int DW = 8;
    localparam int PW = 5;
    localparam int AW = 4;

    localparam logic [3:0] NOP = 4'd0,  LDI = 4'd1,  LDA = 4'd2,  ADD = 4'd3,
                           SUB = 4'd4,  ST  = 4'd7,  LD  = 4'd8,  JMP = 4'd9,
                           JZ  = 4'd10, JC  = 4'd11, OUT = 4'd12, ADDI = 4'd13,
                           SHL = 4'd14, HLT = 4'd15;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, prog_we = 1'b0;
    logic [DW-1:0] A = '0;
    logic [PW-1:0] prog_addr = '0;
    logic [DW+3:0] prog_data = '0;
    logic [DW-1:0] Output;
    logic          out_valid, Halt_out, busy;

    acc_cpu_param #(.DATA_W(DW), .PC_W(PW), .DM_AW(AW), .AUTOSTART(1'b0)) dut (
        .clk(clk), .rst(rst), .A(A), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .Output(Output),
        .out_valid(out_valid), .Halt_out(Halt_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instruction-level reference machine.
    logic [DW+3:0] pm [2**PW];
    logic [DW-1:0] dm [2**AW];
    logic [PW-1:0] m_pc;
    logic [DW-1:0] m_acc, m_out;
    logic          m_c, m_halt;
    logic [DW-1:0] outs [$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic wr(int addr, logic [3:0] op, logic [DW-1:0] opr);
        prog_we = 1'b1; prog_addr = addr[PW-1:0]; prog_data = {op, opr};
        @(posedge clk); #1;
        prog_we = 1'b0;
        pm[addr] = {op, opr};
    endtask

    task automatic step(output bit ov);
        logic [DW+3:0] ir;
        logic [3:0]    op;
        logic [DW-1:0] opr, mv;
        logic [DW:0]   s;
        ir = pm[m_pc];
        m_pc = m_pc + 1'b1;
        op = ir[DW+3:DW];
        opr = ir[DW-1:0];
        mv = dm[opr[AW-1:0]];
        ov = 1'b0;
        case (op)
            1:  m_acc = opr;
            2:  m_acc = A;
            3:  begin s = {1'b0, m_acc} + {1'b0, mv}; m_c = s[DW]; m_acc = s[DW-1:0]; end
            4:  begin m_c = (m_acc < mv); m_acc = m_acc - mv; end
            5:  m_acc = m_acc & mv;
            6:  m_acc = m_acc | mv;
            7:  dm[opr[AW-1:0]] = m_acc;
            8:  m_acc = mv;
            9:  m_pc = opr[PW-1:0];
            10: if (m_acc == 0) m_pc = opr[PW-1:0];
            11: if (m_c) m_pc = opr[PW-1:0];
            12: begin m_out = m_acc; ov = 1'b1; end
            13: begin s = {1'b0, m_acc} + {1'b0, opr}; m_c = s[DW]; m_acc = s[DW-1:0]; end
            14: begin m_c = m_acc[DW-1]; m_acc = m_acc << 1; end
            15: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    // Start the program and check every cycle against the reference machine
    // for up to max_ins instructions. sw: program write in the start cycle.
    // poke: program write attempted while busy (must be ignored).
    task automatic run(int max_ins, bit poke, bit sw, int sw_addr,
                       logic [DW+3:0] sw_word, output int pulses);
        bit ov;
        outs.delete();
        pulses = 0;
        if (sw) begin
            prog_we = 1'b1; prog_addr = sw_addr[PW-1:0]; prog_data = sw_word;
            pm[sw_addr] = sw_word;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0;
        m_pc = '0; m_acc = '0; m_c = 1'b0; m_halt = 1'b0;
        chk("busy_start", busy, 1);
        chk("halt_start", Halt_out, 0);
        chk("ov_start", out_valid, 0);
        for (int k = 0; k < max_ins && !m_halt; k++) begin
            if (poke && k == 0) begin
                prog_we = 1'b1; prog_addr = 5'd1; prog_data = '0;
            end
            @(posedge clk); #1;
            chk("busy_exec", busy, 1);
            chk("ov_exec", out_valid, 0);
            chk("halt_exec", Halt_out, 0);
            @(posedge clk); #1;
            prog_we = 1'b0;
            step(ov);
            chk("out_valid", out_valid, ov);
            chk("output", Output, m_out);
            chk("halt", Halt_out, m_halt);
            chk("busy", busy, !m_halt);
            if (ov) begin pulses++; outs.push_back(Output); end
        end
    endtask

    task automatic do_reset(int cyc);
        rst = 1'b0;
        repeat (cyc) @(posedge clk);
        #1 rst = 1'b1;
        m_out = '0; m_halt = 1'b0;
        chk("rst_output", Output, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_halt", Halt_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pc", dut.pc, 0);
    endtask

    initial begin
        int p;
        logic [DW-1:0] keep;
        #1;
        // reset and idle with AUTOSTART off
        do_reset(2);
        repeat (5) begin
            @(posedge clk); #1;
            chk("idle_busy", busy, 0);
            chk("idle_halt", Halt_out, 0);
            chk("idle_output", Output, 0);
            chk("idle_pc", dut.pc, 0);
        end

        // fill the data RAM with known values
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 8; i++) begin
                wr(2 * i, LDI, DW'($urandom));
                wr(2 * i + 1, ST, DW'(h * 8 + i));
            end
            wr(16, HLT, '0);
            run(20, 0, 0, 0, '0, p);
        end

        // carry and JC
        wr(0, LDI, 8'hFF); wr(1, ST, 8'd3); wr(2, LDI, 8'h02); wr(3, ADD, 8'd3);
        wr(4, JC, 8'd6);   wr(5, OUT, 8'd0); wr(6, OUT, 8'd0); wr(7, HLT, 8'd0);
        run(20, 0, 0, 0, '0, p);
        chk("carry_pulses", p, 1);
        chk("carry_out", Output, 8'h01);
        chk("carry_c", dut.c, 1);

        // countdown loop with JZ
        wr(0, LDI, 8'd3); wr(1, ST, 8'd0); wr(2, LDI, 8'd1); wr(3, ST, 8'd1);
        wr(4, LD, 8'd0);  wr(5, SUB, 8'd1); wr(6, ST, 8'd0); wr(7, OUT, 8'd0);
        wr(8, JZ, 8'd10); wr(9, JMP, 8'd4); wr(10, HLT, 8'd0);
        run(40, 0, 0, 0, '0, p);
        chk("loop_pulses", p, 3);
        if (p == 3) begin
            chk("loop_out0", outs[0], 8'h02);
            chk("loop_out1", outs[1], 8'h01);
            chk("loop_out2", outs[2], 8'h00);
        end

        // the original lab program
        A = 8'h42;
        wr(0, LDA, 8'd0); wr(1, ADDI, 8'd1); wr(2, OUT, 8'd0); wr(3, HLT, 8'd0);
        run(10, 0, 0, 0, '0, p);
        chk("lab_pulses", p, 1);
        chk("lab_out", Output, 8'h43);
        repeat (2) begin
            @(posedge clk); #1;
            chk("lab_halt_hold", Halt_out, 1);
            chk("lab_busy_halt", busy, 0);
        end

        // reprogram in HALT; word 0 written in the start cycle itself
        wr(1, HLT, 8'd0);
        run(5, 0, 1, 0, {OUT, 8'd0}, p);
        chk("reprog_pulses", p, 1);
        chk("reprog_out", Output, 8'h00);

        // writes while busy are dropped
        run(5, 1, 0, 0, '0, p);
        chk("poke_pmem", dut.pmem[1], {HLT, 8'd0});

        // PC wraps from the top address back to 0 without halting
        wr(0, JC, 8'd4); wr(1, LDI, 8'h80); wr(2, SHL, 8'd0); wr(3, JMP, 8'd31);
        wr(4, HLT, 8'd0); wr(31, NOP, 8'd0);
        run(12, 0, 0, 0, '0, p);
        chk("wrap_halt", Halt_out, 1);
        chk("wrap_pc", dut.pc, 5);

        // reset landing on EXEC of ST aborts the store
        keep = dm[2];
        wr(0, LDI, keep ^ 8'h5A); wr(1, ST, 8'd2); wr(2, HLT, 8'd0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("mid_busy", busy, 1);
        do_reset(1);
        chk("mid_ram", dut.dram[2], keep);
        @(posedge clk); #1;
        chk("mid_idle", busy, 0);

        // random programs
        repeat (20) begin
            do_reset(1);
            A = DW'($urandom);
            for (int i = 0; i < 2**PW; i++)
                wr(i, 4'($urandom_range(0, 15)), DW'($urandom));
            run(60, 0, 0, 0, '0, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
